// File: rtl/grant_controller.sv
// rtl/grant_controller.sv - registered, held, aged one-hot grant around a combinational priority arbiter
module grant_controller #(
   parameter int N          = 8,
   parameter int PRIO_BITS  = 3,
   parameter int SEL_W      = 3,
   parameter int AGE_PERIOD = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req_i,
   input  logic [N-1:0]           done_i,
   input  logic [N*PRIO_BITS-1:0] base_prio_i,
   output logic [N-1:0]           arb_req_o,
   output logic [N*PRIO_BITS-1:0] arb_prio_o,
   input  logic                   arb_req_i,
   input  logic [SEL_W-1:0]       arb_sel_i,
   output logic [N-1:0]           gnt_o,
   output logic                   gnt_valid_o,
   output logic [SEL_W-1:0]       gnt_sel_o,
   output logic [PRIO_BITS-1:0]   gnt_prio_o
);

   localparam int PW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t               state;
   logic [PRIO_BITS-1:0] age  [N];
   logic [PRIO_BITS-1:0] base [N];
   logic [PRIO_BITS-1:0] eff  [N];
   logic [PW-1:0]        presc;
   logic                 tick;
   logic                 take;

   assign tick = (presc == PW'(AGE_PERIOD - 1));
   assign take = (state == IDLE) && arb_req_i;

   // Only offer requests to the arbiter while idle; reset masks them at once
   assign arb_req_o = ((state == IDLE) && !rst) ? req_i : '0;

   // Effective priority = base minus age, floored at zero
   always_comb begin
      arb_prio_o = '0;
      for (int k = 0; k < N; k++) begin
         base[k] = base_prio_i[k*PRIO_BITS +: PRIO_BITS];
         eff[k]  = (base[k] > age[k]) ? (base[k] - age[k]) : '0;
         arb_prio_o[k*PRIO_BITS +: PRIO_BITS] = eff[k];
      end
   end

   // Free-running aging prescaler, wraps at AGE_PERIOD-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Age waiting requesters on each tick; clear on grant or when the request drops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) age[k] <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!req_i[k] || (take && (arb_sel_i == SEL_W'(k)))) begin
               age[k] <= '0;
            end else if (tick && !(gnt_valid_o && (gnt_sel_o == SEL_W'(k)))
                         && (age[k] < base[k])) begin
               age[k] <= age[k] + PRIO_BITS'(1);
            end
         end
      end
   end

   // Grant FSM: capture the arbiter winner, hold until release, then one dead cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         gnt_o       <= '0;
         gnt_valid_o <= 1'b0;
         gnt_sel_o   <= '0;
         gnt_prio_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_req_i) begin
                  gnt_o       <= N'(1) << arb_sel_i;
                  gnt_sel_o   <= arb_sel_i;
                  gnt_prio_o  <= eff[arb_sel_i];
                  gnt_valid_o <= 1'b1;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (done_i[gnt_sel_o] || !req_i[gnt_sel_o]) begin
                  gnt_o       <= '0;
                  gnt_valid_o <= 1'b0;
                  state       <= RELEASE;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grant_controller.sv
// tb/tb_grant_controller.sv - scoreboard bench for grant_controller with a behavioural arbiter
module tb_grant_controller;

   localparam int N  = 8;
   localparam int PB = 3;
   localparam int SW = 3;
   localparam int AP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N-1:0]  done;
   logic [N*PB-1:0] base_bus;
   logic [N-1:0]  arb_req_o;
   logic [N*PB-1:0] arb_prio_o;
   logic          arb_req_i;
   logic [SW-1:0] arb_sel_i;
   logic [N-1:0]  gnt;
   logic          gv;
   logic [SW-1:0] gs;
   logic [PB-1:0] gp;

   logic [PB-1:0] b [N];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [N-1:0]    gnt;
      logic            valid;
      logic [SW-1:0]   sel;
      logic [PB-1:0]   prio;
      logic [N-1:0]    areq;
      logic [N*PB-1:0] aprio;
   } exp_t;

   exp_t sbq[$];

   int            m_state;
   logic [PB-1:0] m_age [N];
   int            m_presc;
   logic          m_valid;
   logic [SW-1:0] m_sel;
   logic [PB-1:0] m_prio;

   logic [PB-1:0] arb_best;
   logic          arb_found;

   always #5 clk = ~clk;

   grant_controller #(.N(N), .PRIO_BITS(PB), .SEL_W(SW), .AGE_PERIOD(AP)) dut (
      .clk(clk),
      .rst(rst),
      .req_i(req),
      .done_i(done),
      .base_prio_i(base_bus),
      .arb_req_o(arb_req_o),
      .arb_prio_o(arb_prio_o),
      .arb_req_i(arb_req_i),
      .arb_sel_i(arb_sel_i),
      .gnt_o(gnt),
      .gnt_valid_o(gv),
      .gnt_sel_o(gs),
      .gnt_prio_o(gp)
   );

   // Pack the per-requester base priorities
   always_comb begin
      base_bus = '0;
      for (int k = 0; k < N; k++) base_bus[k*PB +: PB] = b[k];
   end

   // Behavioural priority arbiter: lowest value wins, lowest index on ties
   always_comb begin
      arb_req_i = |arb_req_o;
      arb_sel_i = '0;
      arb_best  = '1;
      arb_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (arb_req_o[k] && (!arb_found || (arb_prio_o[k*PB +: PB] < arb_best))) begin
            arb_found = 1'b1;
            arb_best  = arb_prio_o[k*PB +: PB];
            arb_sel_i = SW'(k);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PB-1:0] m_eff(input int k);
      return (b[k] > m_age[k]) ? PB'(b[k] - m_age[k]) : '0;
   endfunction

   task automatic model_reset();
      m_state = 0;
      for (int k = 0; k < N; k++) m_age[k] = '0;
      m_presc = 0;
      m_valid = 1'b0;
      m_sel   = '0;
      m_prio  = '0;
      sbq.delete();
   endtask

   // Predict one clock edge, push the expectation, then compare after the edge
   task automatic step(input string tag);
      logic          tick;
      logic          take;
      int            win;
      logic [PB-1:0] best;
      logic [PB-1:0] na [N];
      exp_t          e;
      tick = (m_presc == AP - 1);
      take = 1'b0;
      win  = 0;
      best = '1;
      if (m_state == 0) begin
         for (int k = 0; k < N; k++) begin
            if (req[k] && (!take || (m_eff(k) < best))) begin
               take = 1'b1;
               best = m_eff(k);
               win  = k;
            end
         end
      end
      for (int k = 0; k < N; k++) begin
         if (!req[k] || (take && (win == k))) na[k] = '0;
         else if (tick && !(m_valid && (m_sel == SW'(k))) && (m_age[k] < b[k]))
            na[k] = PB'(m_age[k] + 3'd1);
         else na[k] = m_age[k];
      end
      case (m_state)
         0: if (take) begin
               m_valid = 1'b1;
               m_sel   = SW'(win);
               m_prio  = best;
               m_state = 1;
            end
         1: if (done[m_sel] || !req[m_sel]) begin
               m_valid = 1'b0;
               m_state = 2;
            end
         default: m_state = 0;
      endcase
      for (int k = 0; k < N; k++) m_age[k] = na[k];
      m_presc = tick ? 0 : m_presc + 1;
      e.gnt   = m_valid ? (8'd1 << m_sel) : 8'd0;
      e.valid = m_valid;
      e.sel   = m_sel;
      e.prio  = m_prio;
      e.areq  = (m_state == 0) ? req : '0;
      for (int k = 0; k < N; k++) e.aprio[k*PB +: PB] = m_eff(k);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
      chk({tag, "_valid"}, 32'(gv), 32'(e.valid));
      if (e.valid) begin
         chk({tag, "_sel"}, 32'(gs), 32'(e.sel));
         chk({tag, "_prio"}, 32'(gp), 32'(e.prio));
      end
      chk({tag, "_arb_req"}, 32'(arb_req_o), 32'(e.areq));
      chk({tag, "_arb_prio"}, 32'(arb_prio_o), 32'(e.aprio));
      chk({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
      chk({tag, "_valid_or"}, 32'(gv), 32'(|gnt));
   endtask

   // Hold reset across two edges and release it between edges
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      req  = 8'hFF;
      done = '0;
      b[0] = 3'd7; b[1] = 3'd6; b[2] = 3'd5; b[3] = 3'd0;
      b[4] = 3'd4; b[5] = 3'd3; b[6] = 3'd2; b[7] = 3'd1;
      model_reset();
      #2;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(gv), 32'd0);
      chk("rst_sel", 32'(gs), 32'd0);
      chk("rst_prio", 32'(gp), 32'd0);
      chk("rst_arb_req", 32'(arb_req_o), 32'd0);

      // Basic grant, ignored done, release by dropping the request
      req = 8'b11011011;
      do_reset();
      step("basic");
      chk("basic_gnt_c", 32'(gnt), 32'h08);
      chk("basic_sel_c", 32'(gs), 32'd3);
      chk("basic_prio_c", 32'(gp), 32'd0);
      chk("basic_arbreq_c", 32'(arb_req_o), 32'd0);
      done = 8'b00000001;
      step("ign_done");
      done = '0;
      chk("ign_done_c", 32'(gnt), 32'h08);
      req = 8'b11010011;
      step("drop_req");
      chk("drop_req_c", 32'(gv), 32'd0);
      step("drop_rel");
      step("drop_next");

      // Release by done, then next winner k7
      req = 8'b11011011;
      do_reset();
      step("g2");
      done = 8'b00001000;
      req  = 8'b11010011;
      step("rel");
      done = '0;
      chk("rel_gnt_c", 32'(gnt), 32'd0);
      step("rel_dead");
      chk("rel_dead_c", 32'(gnt), 32'd0);
      step("next");
      chk("next_sel_c", 32'(gs), 32'd7);
      chk("next_prio_c", 32'(gp), 32'd1);

      // Anti-starvation
      for (int k = 0; k < N; k++) b[k] = 3'd7;
      b[0] = 3'd5;
      b[1] = 3'd2;
      req  = 8'b00000011;
      do_reset();
      chk("starve_k0_init", 32'(arb_prio_o[2:0]), 32'd5);
      step("starve_g");
      chk("starve_g_sel_c", 32'(gs), 32'd1);
      for (int e = 2; e <= 16; e++) begin
         step("starve_hold");
         if ((e % 4) == 0) chk("starve_k0_eff", 32'(arb_prio_o[2:0]), 32'(5 - e / 4));
      end
      req = 8'b00000001;
      step("starve_rel");
      req = 8'b00000011;
      step("starve_dead");
      step("starve_win");
      chk("starve_sel_c", 32'(gs), 32'd0);
      chk("starve_prio_c", 32'(gp), 32'd1);
      chk("starve_age_clr", 32'(arb_prio_o[2:0]), 32'd5);

      // Saturation of a low base priority
      for (int k = 0; k < N; k++) b[k] = 3'd7;
      b[0] = 3'd0;
      b[2] = 3'd1;
      req  = 8'b00000101;
      do_reset();
      step("sat_g");
      for (int i = 0; i < 40; i++) step("sat_wait");
      chk("sat_k2_eff", 32'(arb_prio_o[8:6]), 32'd0);
      req = 8'b00000100;
      step("sat_rel");
      step("sat_dead");
      step("sat_win");
      chk("sat_sel_c", 32'(gs), 32'd2);
      chk("sat_prio_c", 32'(gp), 32'd0);

      // Asynchronous reset in the middle of a grant
      req = 8'b00000101;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_valid", 32'(gv), 32'd0);
      chk("arst_arb_req", 32'(arb_req_o), 32'd0);
      chk("arst_ages", 32'(arb_prio_o), 32'(base_bus));
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step("post_rst");
      chk("post_rst_valid_c", 32'(gv), 32'd1);
      chk("post_rst_sel_c", 32'(gs), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
